fpga1_sender: RTL and testbench

FPGA1_SENDER -- requirements
Module: fpga1_sender

---
 rtl/fpga_link_pkg.sv | 19 +
 rtl/fpga1_sender_if.sv | 25 ++
 rtl/link_sync2.sv | 23 ++
 rtl/fpga1_sender.sv | 113 +++++++++++
 tb/tb_fpga1_sender.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA1 -> FPGA2 word link: data width, default
// burst timing and the sender FSM state encoding.
package fpga_link_pkg;

  localparam int DATA_W          = 32;
  localparam int CNT_W           = 9;
  localparam int BURST_LEN_DEF   = 16;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF     = 1024;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SEND,
    DONE,
    RELEASE
  } link_state_e;

endpackage

// File: rtl/fpga1_sender_if.sv
// Source stream plus inter-FPGA link signals of the sender.
// The master view is the sender itself; the slave view is its environment.
interface fpga1_sender_if;
  import fpga_link_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] data_out;
  logic              req_out;
  logic              send_done;
  logic              rdy_in;
  logic              ack_in;

  modport master (
    input  s_data, s_valid, rdy_in, ack_in,
    output s_ready, data_out, req_out, send_done
  );

  modport slave (
    output s_data, s_valid, rdy_in, ack_in,
    input  s_ready, data_out, req_out, send_done
  );

endinterface

// File: rtl/link_sync2.sv
// Two-flop synchronizer for one asynchronous control bit from the receiver.
module link_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fpga1_sender.sv
// Burst sender: requests the link, holds each source word on data_out for
// HOLD_CYCLES clocks, then completes a done/ack handshake with the receiver.
module fpga1_sender
  import fpga_link_pkg::*;
#(
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  fpga1_sender_if.master     link,
  output logic               busy,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   burst_cnt
);

  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] SLOT_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(BURST_LEN);

  link_state_e        state, state_nxt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [HOLD_W-1:0]  slot_cnt;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               rdy_s, ack_s;
  logic               xfer, tmo_expire, slot_first, slot_last;

  link_sync2 u_rdy_sync (.clk(clk), .rst(rst), .d(link.rdy_in), .q(rdy_s));
  link_sync2 u_ack_sync (.clk(clk), .rst(rst), .d(link.ack_in), .q(ack_s));

  assign slot_first = (slot_cnt == '0);
  assign slot_last  = (slot_cnt == SLOT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    xfer       = 1'b0;
    tmo_expire = 1'b0;
    case (state)
      IDLE: if (link.s_valid) state_nxt = REQ;
      REQ: begin
        if (rdy_s)                    state_nxt  = SEND;
        else if (tmo_cnt == TMO_LAST) tmo_expire = 1'b1;
      end
      SEND: begin
        // rdy_s is deliberately ignored here: once started, a burst runs out.
        if (slot_first) begin
          if (link.s_valid) xfer      = 1'b1;
          else              state_nxt = DONE;
        end else if (slot_last && (cnt_q == BURST_MAX || !link.s_valid)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (ack_s)                    state_nxt  = RELEASE;
        else if (tmo_cnt == TMO_LAST) tmo_expire = 1'b1;
      end
      RELEASE: begin
        if (!ack_s)                   state_nxt  = IDLE;
        else if (tmo_cnt == TMO_LAST) tmo_expire = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo_expire) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      slot_cnt <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= tmo_expire;

      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (state == REQ || state == DONE || state == RELEASE)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state != SEND || state_nxt != SEND || slot_last)
        slot_cnt <= '0;
      else
        slot_cnt <= slot_cnt + 1'b1;

      if (state == IDLE && state_nxt == REQ)
        cnt_q <= '0;
      else if (xfer)
        cnt_q <= cnt_q + 1'b1;

      if (xfer) data_q <= link.s_data;
    end
  end

  assign link.data_out  = data_q;
  assign link.req_out   = (state == REQ) || (state == SEND) || (state == DONE);
  assign link.send_done = (state == DONE);
  assign link.s_ready   = xfer;
  assign busy           = (state != IDLE);
  assign timeout_err    = err_q;
  assign burst_cnt      = cnt_q;

endmodule

// File: tb/tb_fpga1_sender.sv
// Directed bench for fpga1_sender: normal, short and back-to-back bursts,
// rdy/ack timeouts and reset in mid-burst, against a simple receiver model.
module tb_fpga1_sender;
  import fpga_link_pkg::*;

  localparam int BL = 4;
  localparam int HC = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy, timeout_err;
  logic [CNT_W-1:0] burst_cnt;

  fpga1_sender_if link ();

  fpga1_sender #(.BURST_LEN(BL), .HOLD_CYCLES(HC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .link(link),
    .busy(busy), .timeout_err(timeout_err), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // source model
  logic [31:0] src_mem [16];
  int          src_idx, src_cnt;
  // receiver model: 0 normal, 1 never ready, 2 ack sticks high
  int          rx_mode;
  int          req_age;
  logic        ack_sticky;

  // per-test observations, indexed by tick number since clear_stats
  logic [31:0] dlog [$];
  int          xfer_cyc [$];
  int          n_xfer, n_ready, n_done_rise, n_req_rise, n_req_fall, n_err, n_dchg;
  int          done_rise_cyc, done_fall_cyc, req_rise_cyc, err_cyc;
  logic        err_req, err_busy, seen_busy;
  logic        prev_done, prev_req;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    link.s_valid = (src_idx < src_cnt);
    link.s_data  = (src_idx < src_cnt) ? src_mem[src_idx] : 32'h0;
    if (link.req_out) req_age++;
    else              req_age = 0;
    link.rdy_in = (rx_mode != 1) && (req_age >= 3);
    if (link.send_done) ack_sticky = 1'b1;
    link.ack_in = (rx_mode == 2) ? ack_sticky : link.send_done;
  endtask

  task automatic start_src(input int n, input logic [31:0] base);
    src_idx = 0;
    src_cnt = n;
    for (int i = 0; i < n; i++) src_mem[i] = base + 32'(i);
    drive_inputs();
  endtask

  task automatic clear_stats();
    dlog.delete();
    xfer_cyc.delete();
    n_xfer = 0; n_ready = 0; n_done_rise = 0; n_req_rise = 0; n_req_fall = 0;
    n_err = 0; n_dchg = 0;
    done_rise_cyc = -1; done_fall_cyc = -1; req_rise_cyc = -1; err_cyc = -1;
    err_req = 1'bx; err_busy = 1'bx; seen_busy = 1'b0;
    prev_done = link.send_done;
    prev_req  = link.req_out;
    prev_data = link.data_out;
  endtask

  // One clock: observe mid-cycle, then update the source and receiver models.
  task automatic tick();
    logic xfer;
    int   t;
    @(negedge clk);
    t    = dlog.size();
    xfer = link.s_valid && link.s_ready;
    dlog.push_back(link.data_out);
    if (xfer) begin n_xfer++; xfer_cyc.push_back(t); end
    if (link.s_ready) n_ready++;
    if (busy) seen_busy = 1'b1;
    if (link.send_done && !prev_done) begin
      n_done_rise++;
      if (done_rise_cyc < 0) done_rise_cyc = t;
    end
    if (!link.send_done && prev_done) done_fall_cyc = t;
    if (link.req_out && !prev_req) begin
      n_req_rise++;
      if (req_rise_cyc < 0) req_rise_cyc = t;
    end
    if (!link.req_out && prev_req) n_req_fall++;
    if (timeout_err) begin
      n_err++;
      if (err_cyc < 0) begin err_cyc = t; err_req = link.req_out; err_busy = busy; end
    end
    if (link.data_out !== prev_data) n_dchg++;
    prev_done = link.send_done;
    prev_req  = link.req_out;
    prev_data = link.data_out;
    @(posedge clk);
    #1;
    if (xfer) src_idx++;
    drive_inputs();
  endtask

  initial begin
    rst = 1'b1;
    rx_mode = 0; req_age = 0; ack_sticky = 1'b0;
    src_idx = 0; src_cnt = 0;
    link.s_valid = 1'b0; link.s_data = '0; link.rdy_in = 1'b0; link.ack_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_req_out",   link.req_out,   1'b0);
    check("rst_send_done", link.send_done, 1'b0);
    check("rst_s_ready",   link.s_ready,   1'b0);
    check("rst_busy",      busy,           1'b0);
    check("rst_tmo_err",   timeout_err,    1'b0);
    check("rst_data_out",  link.data_out,  32'h0);
    check("rst_burst_cnt", burst_cnt,      9'd0);
    rst = 1'b0;
    repeat (2) tick();

    // normal burst A0..A3
    clear_stats();
    start_src(4, 32'hA0);
    for (int i = 0; i < 200 && !(seen_busy && !busy); i++) tick();
    check("nrm_finished",  seen_busy && !busy, 1'b1);
    check("nrm_xfers",     n_xfer,       4);
    check("nrm_dchg",      n_dchg,       4);
    check("nrm_done_once", n_done_rise,  1);
    check("nrm_burst_cnt", burst_cnt,    9'd4);
    check("nrm_last_word", link.data_out, 32'hA3);
    check("nrm_no_err",    n_err,        0);
    for (int i = 0; i < xfer_cyc.size() && i < 4; i++) begin
      check($sformatf("nrm_word%0d_first", i), dlog[xfer_cyc[i] + 1],  32'hA0 + 32'(i));
      check($sformatf("nrm_word%0d_last", i),  dlog[xfer_cyc[i] + HC], 32'hA0 + 32'(i));
    end
    if (xfer_cyc.size() == 4) check("nrm_slot_span", xfer_cyc[3] - xfer_cyc[0], 3 * HC);

    // short burst: two words only
    clear_stats();
    start_src(2, 32'hB0);
    for (int i = 0; i < 200 && !(seen_busy && !busy); i++) tick();
    check("sht_finished",  seen_busy && !busy, 1'b1);
    check("sht_xfers",     n_xfer,      2);
    check("sht_burst_cnt", burst_cnt,   9'd2);
    check("sht_done_once", n_done_rise, 1);
    check("sht_last_word", link.data_out, 32'hB1);
    if (xfer_cyc.size() == 2) check("sht_done_delay", done_rise_cyc - xfer_cyc[1], HC);

    // receiver never ready: REQ times out
    rx_mode = 1;
    clear_stats();
    start_src(1, 32'hC0);
    for (int i = 0; i < 10 && req_rise_cyc < 0; i++) tick();
    check("nordy_req_seen", req_rise_cyc >= 0, 1'b1);
    src_cnt = src_idx;
    drive_inputs();
    for (int i = 0; i < 40 && err_cyc < 0; i++) tick();
    check("nordy_err_seen",  err_cyc >= 0, 1'b1);
    check("nordy_err_delay", err_cyc - req_rise_cyc, TO);
    check("nordy_err_req",   err_req,  1'b0);
    check("nordy_err_busy",  err_busy, 1'b0);
    repeat (3) tick();
    check("nordy_err_pulse", n_err,   1);
    check("nordy_no_ready",  n_ready, 0);
    check("nordy_idle",      busy,    1'b0);
    rx_mode = 0;

    // ack stuck high: RELEASE times out
    rx_mode = 2; ack_sticky = 1'b0;
    clear_stats();
    start_src(1, 32'hD0);
    for (int i = 0; i < 100 && err_cyc < 0; i++) tick();
    check("ack_err_seen",  err_cyc >= 0, 1'b1);
    check("ack_done_once", n_done_rise, 1);
    check("ack_rel_delay", err_cyc - done_fall_cyc, TO);
    repeat (3) tick();
    check("ack_err_pulse", n_err,        1);
    check("ack_idle",      busy,         1'b0);
    check("ack_req_low",   link.req_out, 1'b0);
    check("ack_burst_cnt", burst_cnt,    9'd1);
    rx_mode = 0; ack_sticky = 1'b0;
    repeat (4) tick();

    // reset in the middle of SEND after two words
    clear_stats();
    start_src(4, 32'hE0);
    for (int i = 0; i < 80 && n_xfer < 2; i++) tick();
    check("mrst_two_words", n_xfer, 2);
    tick();
    rst = 1'b1;
    tick();
    check("mrst_req_out",   link.req_out,   1'b0);
    check("mrst_send_done", link.send_done, 1'b0);
    check("mrst_s_ready",   link.s_ready,   1'b0);
    check("mrst_busy",      busy,           1'b0);
    check("mrst_tmo_err",   timeout_err,    1'b0);
    check("mrst_data_out",  link.data_out,  32'h0);
    check("mrst_burst_cnt", burst_cnt,      9'd0);
    src_cnt = src_idx;
    drive_inputs();
    rst = 1'b0;
    repeat (4) tick();
    check("mrst_no_done", n_done_rise, 0);
    check("mrst_no_err",  n_err,       0);
    check("mrst_idle",    busy,        1'b0);

    // back-to-back: eight words make two full bursts
    clear_stats();
    start_src(8, 32'hF0);
    for (int i = 0; i < 400 && !(n_xfer == 8 && !busy); i++) tick();
    check("b2b_finished",  n_xfer == 8 && !busy, 1'b1);
    check("b2b_done_two",  n_done_rise, 2);
    check("b2b_req_rise",  n_req_rise,  2);
    check("b2b_req_fall",  n_req_fall,  2);
    check("b2b_burst_cnt", burst_cnt,   9'd4);
    check("b2b_last_word", link.data_out, 32'hF7);
    check("b2b_dchg",      n_dchg, 8);
    check("b2b_no_err",    n_err,  0);
    if (xfer_cyc.size() == 8) check("b2b_word4", dlog[xfer_cyc[4] + 1], 32'hF4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
